// File: rtl/ssp_pkg.sv
// Shared SSP definitions: default FIFO geometry and the interrupt-threshold clamp
// used by both the receive and transmit FIFOs.
package ssp_pkg;

    localparam int unsigned SSP_DATA_WIDTH = 8;
    localparam int unsigned SSP_RX_DEPTH   = 4;

    // Out-of-range thresholds are folded into 1..depth so the level compare stays meaningful.
    function automatic int unsigned clamp_threshold(input int unsigned thr, input int unsigned depth);
        if (thr == 32'd0) begin
            return 32'd1;
        end
        if (thr > depth) begin
            return depth;
        end
        return thr;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers and occupancy counter for a power-of-two circular FIFO.
// Full and empty come from the level counter, so the pointers may be equal in both cases.
module fifo_ptr_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_req,
    input  logic          pop_req,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          wr_en,
    output logic          overrun
);

    localparam logic [AW:0] LEVEL_MAX = (AW + 1)'(DEPTH);

    logic do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LEVEL_MAX);
    assign do_pop  = pop_req & ~empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign wr_en   = push_req & (~full | do_pop);
    assign overrun = push_req & full & ~do_pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !do_pop) begin
                level <= level + (AW + 1)'(1);
            end else if (do_pop && !wr_en) begin
                level <= level - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/rx_fifo_param.sv
// SSP receive FIFO: buffers words from the receive shifter and presents the head
// word show-ahead on the APB read path, with level/overrun interrupts and status.
module rx_fifo_param
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SSP_DATA_WIDTH,
    parameter int unsigned DEPTH      = SSP_RX_DEPTH,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  PCLK,
    input  logic                  CLEAR_B,
    input  logic                  PSEL,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] RxData,
    input  logic                  NextWord,
    input  logic [AW:0]           RxThreshold,
    input  logic                  OverrunClr,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  SSPRXINTR,
    output logic                  SSPRORINTR,
    output logic [AW:0]           RxLevel,
    output logic                  RxEmpty,
    output logic                  RxFull
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_en;
    logic                  overrun;
    logic [AW:0]           thr_eff;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr_ctrl (
        .clk      (PCLK),
        .rst_n    (CLEAR_B),
        .push_req (NextWord),
        .pop_req  (PSEL & ~PWRITE),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .level    (RxLevel),
        .empty    (RxEmpty),
        .full     (RxFull),
        .wr_en    (wr_en),
        .overrun  (overrun)
    );

    // NOTE: storage is deliberately not reset; empty gating on PRDATA hides stale contents.
    always_ff @(posedge PCLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= RxData;
        end
    end

    // Overrun has priority over the clear so a coincident overrun is never lost.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            SSPRORINTR <= 1'b0;
        end else if (overrun) begin
            SSPRORINTR <= 1'b1;
        end else if (OverrunClr) begin
            SSPRORINTR <= 1'b0;
        end
    end

    assign PRDATA    = RxEmpty ? '0 : mem[rd_ptr];
    assign thr_eff   = (AW + 1)'(clamp_threshold(32'(RxThreshold), DEPTH));
    assign SSPRXINTR = (RxLevel >= thr_eff);

endmodule

// File: tb/tb_rx_fifo_param.sv
// Bench for rx_fifo_param: a vector table on a 4x8 instance and a queue-based
// reference model driving an 8x16 instance with directed and random traffic.
module tb_rx_fifo_param;

    logic        PCLK;

    logic        a_clear_b, a_psel, a_pwrite, a_next, a_ovr_clr;
    logic [7:0]  a_data, a_prdata;
    logic [2:0]  a_thr, a_level;
    logic        a_rxintr, a_rorintr, a_empty, a_full;

    logic        b_clear_b, b_psel, b_pwrite, b_next, b_ovr_clr;
    logic [15:0] b_data, b_prdata;
    logic [3:0]  b_thr, b_level;
    logic        b_rxintr, b_rorintr, b_empty, b_full;

    rx_fifo_param #(.DATA_WIDTH(8), .DEPTH(4)) dut_a (
        .PCLK(PCLK), .CLEAR_B(a_clear_b), .PSEL(a_psel), .PWRITE(a_pwrite),
        .RxData(a_data), .NextWord(a_next), .RxThreshold(a_thr), .OverrunClr(a_ovr_clr),
        .PRDATA(a_prdata), .SSPRXINTR(a_rxintr), .SSPRORINTR(a_rorintr),
        .RxLevel(a_level), .RxEmpty(a_empty), .RxFull(a_full)
    );

    rx_fifo_param #(.DATA_WIDTH(16), .DEPTH(8)) dut_b (
        .PCLK(PCLK), .CLEAR_B(b_clear_b), .PSEL(b_psel), .PWRITE(b_pwrite),
        .RxData(b_data), .NextWord(b_next), .RxThreshold(b_thr), .OverrunClr(b_ovr_clr),
        .PRDATA(b_prdata), .SSPRXINTR(b_rxintr), .SSPRORINTR(b_rorintr),
        .RxLevel(b_level), .RxEmpty(b_empty), .RxFull(b_full)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Vector: inputs held for one edge, then outputs expected just after that edge.
    typedef struct {
        string name;
        int psel, pwrite, nw, data, thr, clr;
        int e_prdata, e_level, e_intr, e_ror, e_empty, e_full;
    } vec_t;

    vec_t vq[$];
    vec_t v;

    // Reference model for instance B: an ordered queue of accepted words plus an overrun bit.
    localparam int B_DEPTH = 8;
    logic [15:0] mq[$];
    bit          m_ovr;

    function automatic int clamp_ref(input int t, input int d);
        return (t == 0) ? 1 : ((t > d) ? d : t);
    endfunction

    task automatic model_step(input bit push, input bit psel, input bit pwrite,
                              input logic [15:0] d, input bit clr);
        bit pop;
        bit set;
        pop = psel && !pwrite && (mq.size() != 0);
        set = 1'b0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < B_DEPTH) mq.push_back(d);
            else set = 1'b1;
        end
        if (set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic check_b(input string tag);
        logic [15:0] head;
        head = (mq.size() != 0) ? mq[0] : 16'h0000;
        check({tag, " PRDATA"}, 32'(b_prdata), 32'(head));
        check({tag, " RxLevel"}, 32'(b_level), 32'(mq.size()));
        check({tag, " SSPRXINTR"}, 32'(b_rxintr), 32'(mq.size() >= clamp_ref(int'(b_thr), B_DEPTH)));
        check({tag, " SSPRORINTR"}, 32'(b_rorintr), 32'(m_ovr));
        check({tag, " RxEmpty"}, 32'(b_empty), 32'(mq.size() == 0));
        check({tag, " RxFull"}, 32'(b_full), 32'(mq.size() == B_DEPTH));
    endtask

    task automatic b_cycle(input string tag, input bit push, input bit psel, input bit pwrite,
                           input logic [15:0] d, input bit clr, input logic [3:0] thr);
        b_next    = push;
        b_psel    = psel;
        b_pwrite  = pwrite;
        b_data    = d;
        b_ovr_clr = clr;
        b_thr     = thr;
        @(posedge PCLK);
        #1;
        model_step(push, psel, pwrite, d, clr);
        check_b(tag);
    endtask

    initial begin
        a_clear_b = 1'b0; a_psel = 1'b0; a_pwrite = 1'b0; a_next = 1'b0;
        a_ovr_clr = 1'b0; a_data = '0; a_thr = 3'd2;
        b_clear_b = 1'b0; b_psel = 1'b0; b_pwrite = 1'b0; b_next = 1'b0;
        b_ovr_clr = 1'b0; b_data = '0; b_thr = 4'd1;
        mq.delete();
        m_ovr = 1'b0;

        // Reset state, sampled before any clock edge.
        #2;
        check("reset A RxLevel", 32'(a_level), 32'd0);
        check("reset A RxEmpty", 32'(a_empty), 32'd1);
        check("reset A RxFull", 32'(a_full), 32'd0);
        check("reset A PRDATA", 32'(a_prdata), 32'h00);
        check("reset A SSPRXINTR", 32'(a_rxintr), 32'd0);
        check("reset A SSPRORINTR", 32'(a_rorintr), 32'd0);
        check_b("reset B");
        #10;
        a_clear_b = 1'b1;
        b_clear_b = 1'b1;

        //             name            psel pw nw data  thr clr  prdata lvl intr ror emp full
        vq.push_back('{"push E7",       0, 0, 1, 'hE7, 2, 0,   'hE7, 1, 0, 0, 0, 0});
        vq.push_back('{"push 3A",       0, 0, 1, 'h3A, 2, 0,   'hE7, 2, 1, 0, 0, 0});
        vq.push_back('{"push 29",       0, 0, 1, 'h29, 2, 0,   'hE7, 3, 1, 0, 0, 0});
        vq.push_back('{"push C5",       0, 0, 1, 'hC5, 2, 0,   'hE7, 4, 1, 0, 0, 1});
        vq.push_back('{"overrun 5F",    0, 0, 1, 'h5F, 2, 0,   'hE7, 4, 1, 1, 0, 1});
        vq.push_back('{"pop E7",        1, 0, 0, 0,    2, 0,   'h3A, 3, 1, 1, 0, 0});
        vq.push_back('{"pop 3A",        1, 0, 0, 0,    2, 0,   'h29, 2, 1, 1, 0, 0});
        vq.push_back('{"pop 29",        1, 0, 0, 0,    2, 0,   'hC5, 1, 0, 1, 0, 0});
        vq.push_back('{"pop C5",        1, 0, 0, 0,    2, 0,   'h00, 0, 0, 1, 1, 0});
        vq.push_back('{"overrun clr",   0, 0, 0, 0,    2, 1,   'h00, 0, 0, 0, 1, 0});
        vq.push_back('{"refill E7",     0, 0, 1, 'hE7, 2, 0,   'hE7, 1, 0, 0, 0, 0});
        vq.push_back('{"refill 3A",     0, 0, 1, 'h3A, 2, 0,   'hE7, 2, 1, 0, 0, 0});
        vq.push_back('{"refill 29",     0, 0, 1, 'h29, 2, 0,   'hE7, 3, 1, 0, 0, 0});
        vq.push_back('{"refill C5",     0, 0, 1, 'hC5, 2, 0,   'hE7, 4, 1, 0, 0, 1});
        vq.push_back('{"full push+pop", 1, 0, 1, 'h11, 2, 0,   'h3A, 4, 1, 0, 0, 1});
        vq.push_back('{"pop 3A b",      1, 0, 0, 0,    2, 0,   'h29, 3, 1, 0, 0, 0});
        vq.push_back('{"pop 29 b",      1, 0, 0, 0,    2, 0,   'hC5, 2, 1, 0, 0, 0});
        vq.push_back('{"pop C5 b",      1, 0, 0, 0,    2, 0,   'h11, 1, 0, 0, 0, 0});
        vq.push_back('{"pop 11",        1, 0, 0, 0,    2, 0,   'h00, 0, 0, 0, 1, 0});
        vq.push_back('{"empty push+pop",1, 0, 1, 'hA5, 2, 0,   'hA5, 1, 0, 0, 0, 0});
        vq.push_back('{"pop A5",        1, 0, 0, 0,    2, 0,   'h00, 0, 0, 0, 1, 0});
        vq.push_back('{"pop on empty",  1, 0, 0, 0,    2, 0,   'h00, 0, 0, 0, 1, 0});
        vq.push_back('{"thr0 push 66",  0, 0, 1, 'h66, 0, 0,   'h66, 1, 1, 0, 0, 0});
        vq.push_back('{"thr7 idle",     0, 0, 0, 0,    7, 0,   'h66, 1, 0, 0, 0, 0});
        vq.push_back('{"thr7 push 77",  0, 0, 1, 'h77, 7, 0,   'h66, 2, 0, 0, 0, 0});
        vq.push_back('{"thr7 push 88",  0, 0, 1, 'h88, 7, 0,   'h66, 3, 0, 0, 0, 0});
        vq.push_back('{"thr7 push 99",  0, 0, 1, 'h99, 7, 0,   'h66, 4, 1, 0, 0, 1});
        vq.push_back('{"overrun+clr",   0, 0, 1, 'hAA, 4, 1,   'h66, 4, 1, 1, 0, 1});
        vq.push_back('{"clr only",      0, 0, 0, 0,    4, 1,   'h66, 4, 1, 0, 0, 1});
        vq.push_back('{"apb write",     1, 1, 0, 0,    4, 0,   'h66, 4, 1, 0, 0, 1});
        vq.push_back('{"pop 66 thr3",   1, 0, 0, 0,    3, 0,   'h77, 3, 1, 0, 0, 0});

        foreach (vq[k]) begin
            v = vq[k];
            a_psel    = v.psel[0];
            a_pwrite  = v.pwrite[0];
            a_next    = v.nw[0];
            a_data    = 8'(v.data);
            a_thr     = 3'(v.thr);
            a_ovr_clr = v.clr[0];
            @(posedge PCLK);
            #1;
            check({v.name, " PRDATA"}, 32'(a_prdata), v.e_prdata);
            check({v.name, " RxLevel"}, 32'(a_level), v.e_level);
            check({v.name, " SSPRXINTR"}, 32'(a_rxintr), v.e_intr);
            check({v.name, " SSPRORINTR"}, 32'(a_rorintr), v.e_ror);
            check({v.name, " RxEmpty"}, 32'(a_empty), v.e_empty);
            check({v.name, " RxFull"}, 32'(a_full), v.e_full);
        end
        a_psel = 1'b0; a_next = 1'b0; a_ovr_clr = 1'b0;

        // 20 sequential words through the 8-deep instance, popping three cycles in four.
        for (int i = 0; i < 20; i++) begin
            b_cycle("seq", 1'b1, (i % 4) != 0, 1'b0, 16'(i + 1), 1'b0, 4'd4);
        end
        check("seq level nonzero", 32'(b_level != 4'd0), 32'd1);

        // Asynchronous reset mid-stream, with no clock edge in between.
        b_next = 1'b0; b_psel = 1'b0;
        #3;
        b_clear_b = 1'b0;
        #1;
        check("async clr RxLevel", 32'(b_level), 32'd0);
        check("async clr RxEmpty", 32'(b_empty), 32'd1);
        check("async clr PRDATA", 32'(b_prdata), 32'h0000);
        check("async clr SSPRORINTR", 32'(b_rorintr), 32'd0);
        mq.delete();
        m_ovr = 1'b0;
        #2;
        b_clear_b = 1'b1;
        check_b("after clr");

        // Random traffic in alternating fill-heavy and drain-heavy phases.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (((i / 60) % 2) != 0) ? 85 : 25;
            b_cycle("rand",
                    $urandom_range(0, 99) < bias,
                    $urandom_range(0, 99) < (110 - bias),
                    $urandom_range(0, 3) == 0,
                    16'($urandom),
                    $urandom_range(0, 15) == 0,
                    4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
